// File: rtl/led_status_scheduler.sv
// Fixed-priority LED sharing scheduler with min-hold arbitration and tick-based patterns.
// Optional LED_PWM_DIM_EN adds a dim[3:0] input that PWM-dims the lit phases.
module led_status_scheduler #(
    parameter int CLOCK_SPEED = 25000000,
    parameter int NUM_REQ     = 4,
    parameter int MIN_HOLD    = 50,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [3*NUM_REQ-1:0] mode,
    input  logic [4*NUM_REQ-1:0] count,
`ifdef LED_PWM_DIM_EN
    input  logic [3:0]           dim,
`endif
    output logic                 LED,
    output logic                 grant_valid,
    output logic [ID_W-1:0]      grant_id,
    output logic                 tick
);

    localparam int TICK_DIV = (CLOCK_SPEED / 100 > 1) ? CLOCK_SPEED / 100 : 2;
    localparam int PW       = $clog2(TICK_DIV);
    localparam int HW       = $clog2(MIN_HOLD + 1);

    localparam logic [2:0] M_ON   = 3'd1;
    localparam logic [2:0] M_SLOW = 3'd2;
    localparam logic [2:0] M_FAST = 3'd3;
    localparam logic [2:0] M_CODE = 3'd4;
    localparam logic [2:0] M_VARY = 3'd5;

    typedef enum logic [2:0] {S_IDLE, S_SHOW, S_CODE_ON, S_CODE_OFF, S_CODE_GAP} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   presc;
    logic [HW-1:0]   hold, hold_n, hold_inc;
    logic [6:0]      phase, phase_n, lim;
    logic [3:0]      pulses, pulses_n, lcount, lcount_n, cur_cnt;
    logic [1:0]      vcnt, vcnt_n;
    logic [2:0]      lmode, lmode_n, cur_mode;
    logic [ID_W-1:0] gid_n, win;
    logic            gv_n, led_pat, led_pat_n, found, rearb;

    assign tick        = (presc == PW'(TICK_DIV - 1));
    assign grant_valid = (state != S_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) presc <= '0;
        else if (tick) presc <= '0;
        else presc <= presc + 1'b1;
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !found) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
    end

    assign cur_mode = mode[3*int'(grant_id) +: 3];
    assign cur_cnt  = count[4*int'(grant_id) +: 4];
    assign hold_inc = (hold >= HW'(MIN_HOLD)) ? hold : hold + 1'b1;

    // Preemption is only considered while showing a plain pattern; CODE yields at its gap end.
    always_comb begin
        rearb = 1'b0;
        if (tick) begin
            if (!grant_valid)
                rearb = found;
            else if (!req[grant_id])
                rearb = 1'b1;
            else if (state == S_SHOW && hold_inc >= HW'(MIN_HOLD) &&
                     (win != grant_id || cur_mode != lmode || cur_cnt != lcount))
                rearb = 1'b1;
            else if (state == S_CODE_GAP && phase == 7'd99)
                rearb = 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        hold_n    = hold;
        phase_n   = phase;
        pulses_n  = pulses;
        vcnt_n    = vcnt;
        lmode_n   = lmode;
        lcount_n  = lcount;
        gid_n     = grant_id;
        gv_n      = grant_valid;
        led_pat_n = led_pat;
        lim       = vcnt[1] ? 7'd9 : 7'd49;
        if (rearb) begin
            hold_n   = '0;
            phase_n  = '0;
            pulses_n = '0;
            vcnt_n   = '0;
            if (found) begin
                lmode_n  = mode[3*int'(win) +: 3];
                lcount_n = count[4*int'(win) +: 4];
                gid_n    = win;
                gv_n     = 1'b1;
                if (lmode_n == M_CODE) begin
                    state_n   = (lcount_n != 4'd0) ? S_CODE_ON : S_CODE_GAP;
                    led_pat_n = (lcount_n != 4'd0);
                end else begin
                    state_n   = S_SHOW;
                    led_pat_n = (lmode_n == M_ON || lmode_n == M_SLOW ||
                                 lmode_n == M_FAST || lmode_n == M_VARY);
                end
            end else begin
                state_n   = S_IDLE;
                gv_n      = 1'b0;
                led_pat_n = 1'b0;
            end
        end else if (tick && grant_valid) begin
            hold_n = hold_inc;
            case (state)
                S_SHOW: begin
                    if (lmode == M_SLOW || lmode == M_FAST || lmode == M_VARY) begin
                        if (lmode == M_SLOW) lim = 7'd49;
                        else if (lmode == M_FAST) lim = 7'd9;
                        if (phase == lim) begin
                            phase_n   = '0;
                            led_pat_n = ~led_pat;
                            vcnt_n    = vcnt + 1'b1;
                        end else begin
                            phase_n = phase + 1'b1;
                        end
                    end else begin
                        led_pat_n = (lmode == M_ON);
                    end
                end
                S_CODE_ON: begin
                    if (phase == 7'd19) begin
                        phase_n   = '0;
                        led_pat_n = 1'b0;
                        pulses_n  = pulses + 1'b1;
                        state_n   = S_CODE_OFF;
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                end
                S_CODE_OFF: begin
                    if (phase == 7'd19) begin
                        phase_n = '0;
                        if (pulses == lcount) begin
                            state_n = S_CODE_GAP;
                        end else begin
                            state_n   = S_CODE_ON;
                            led_pat_n = 1'b1;
                        end
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                end
                S_CODE_GAP: phase_n = phase + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            hold     <= '0;
            phase    <= '0;
            pulses   <= '0;
            vcnt     <= '0;
            lmode    <= '0;
            lcount   <= '0;
            grant_id <= '0;
            led_pat  <= 1'b0;
        end else begin
            state    <= gv_n ? state_n : S_IDLE;
            hold     <= hold_n;
            phase    <= phase_n;
            pulses   <= pulses_n;
            vcnt     <= vcnt_n;
            lmode    <= lmode_n;
            lcount   <= lcount_n;
            grant_id <= gid_n;
            led_pat  <= led_pat_n;
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pwm_cnt <= '0;
        else pwm_cnt <= pwm_cnt + 1'b1;
    end

    assign LED = led_pat && (pwm_cnt < dim);
`else
    assign LED = led_pat;
`endif

endmodule

// File: tb/tb_led_status_scheduler.sv
// Directed bench for led_status_scheduler at CLOCK_SPEED=1000 (one tick per 10 clocks).
// Cycle n = n-th rising edge after reset release; tick k takes effect at cycle 10k.
module tb_led_status_scheduler;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [11:0] mode;
    logic [15:0] count;
    logic        LED, grant_valid, tick;
    logic [1:0]  grant_id;
`ifdef LED_PWM_DIM_EN
    logic [3:0]  dim;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clock = ~clock;

    led_status_scheduler #(.CLOCK_SPEED(1000), .NUM_REQ(4), .MIN_HOLD(50)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .mode        (mode),
        .count       (count),
`ifdef LED_PWM_DIM_EN
        .dim         (dim),
`endif
        .LED         (LED),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .tick        (tick)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Lit phases are PWM-chopped in the dimming build, so only dark phases are compared there.
    task automatic check_led(input string tag, input int exp);
`ifdef LED_PWM_DIM_EN
        if (exp == 0) check_eq(tag, int'(LED), exp);
`else
        check_eq(tag, int'(LED), exp);
`endif
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clock);
            cyc++;
        end
        #1;
    endtask

    task automatic set_src(input int i, input logic [2:0] m, input logic [3:0] c);
        mode[3*i +: 3]  = m;
        count[4*i +: 4] = c;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_eq("rst_gv", int'(grant_valid), 0);
        check_eq("rst_led", int'(LED), 0);
        check_eq("rst_gid", int'(grant_id), 0);
        check_eq("rst_tick", int'(tick), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        int tk, lit, gvs;
        req   = 4'b1111;
        mode  = '0;
        count = '0;
`ifdef LED_PWM_DIM_EN
        dim = 4'd15;
`endif
        for (int i = 0; i < 4; i++) set_src(i, 3'd1, 4'd0);

        // Reset held with every source requesting: nothing may happen.
        reset_n = 1'b0;
        tk = 0; lit = 0; gvs = 0;
        repeat (20) @(negedge clock) begin
            tk  += int'(tick);
            lit += int'(LED);
            gvs += int'(grant_valid);
        end
        check_eq("hold_rst_ticks", tk, 0);
        check_eq("hold_rst_led", lit, 0);
        check_eq("hold_rst_gv", gvs, 0);
        reset_n = 1'b1;
        cyc = 0;
        goto(8);  check_eq("pre_tick", int'(tick), 0);
        goto(9);  check_eq("first_tick", int'(tick), 1);
                  check_eq("first_tick_gv", int'(grant_valid), 0);
        goto(10); check_eq("grant0_gv", int'(grant_valid), 1);
                  check_eq("grant0_id", int'(grant_id), 0);
                  check_led("grant0_led", 1);
                  check_eq("tick_one_clock", int'(tick), 0);

        // SLOW on source 2, then a mode change after hold saturates.
        req = 4'b0100;
        set_src(2, 3'd2, 4'd0);
        do_reset();
        goto(10);   check_eq("slow_id", int'(grant_id), 2);
                    check_led("slow_first", 1);
        goto(509);  check_led("slow_509", 1);
        goto(510);  check_led("slow_510", 0);
        goto(1009); check_led("slow_1009", 0);
        goto(1010); check_led("slow_1010", 1);
        set_src(2, 3'd0, 4'd0);
        goto(1019); check_led("modechg_1019", 1);
        goto(1020); check_led("modechg_1020", 0);
                    check_eq("modechg_gv", int'(grant_valid), 1);
        goto(1025);

        // CODE, count 3: period 220 ticks.
        req = 4'b0010;
        set_src(1, 3'd4, 4'd3);
        do_reset();
        goto(10);   check_eq("code_id", int'(grant_id), 1);
                    check_led("code_p1_on", 1);
        goto(209);  check_led("code_209", 1);
        goto(210);  check_led("code_210", 0);
        goto(410);  check_led("code_p2_on", 1);
        goto(1009); check_led("code_p3_end", 1);
        goto(1010); check_led("code_dark", 0);
        goto(2209); check_led("code_gap_end", 0);
        goto(2210); check_led("code_repeat", 1);
                    check_eq("code_repeat_id", int'(grant_id), 1);

        // Preemption held off until 50 ticks after the grant.
        req = 4'b1000;
        set_src(3, 3'd1, 4'd0);
        do_reset();
        goto(10);  check_eq("pre_id3", int'(grant_id), 3);
        goto(100);
        set_src(0, 3'd3, 4'd0);
        req[0] = 1'b1;
        goto(110); check_eq("pre_held_110", int'(grant_id), 3);
        goto(509); check_eq("pre_held_509", int'(grant_id), 3);
        goto(510); check_eq("pre_switch", int'(grant_id), 0);
                   check_led("fast_first", 1);
        goto(609); check_led("fast_609", 1);
        goto(610); check_led("fast_610", 0);
        goto(615);
        req[0] = 1'b0;
        goto(620); check_eq("drop_regrant", int'(grant_id), 3);
                   check_led("drop_led", 1);

        // CODE is only yielded at its gap end, except on request drop.
        req = 4'b1100;
        set_src(2, 3'd4, 4'd1);
        set_src(3, 3'd0, 4'd0);
        do_reset();
        goto(10);   check_eq("nt_id", int'(grant_id), 2);
        goto(600);
        set_src(0, 3'd1, 4'd0);
        req[0] = 1'b1;
        goto(1409); check_eq("nt_held", int'(grant_id), 2);
                    check_led("nt_gap", 0);
        goto(1410); check_eq("nt_switch", int'(grant_id), 0);
                    check_led("nt_on", 1);
        req[0] = 1'b0;
        goto(1420); check_eq("nt_back", int'(grant_id), 2);
                    check_led("nt_back_led", 1);
        goto(1500);
        req[2] = 1'b0;
        goto(1509); check_eq("mid_held", int'(grant_id), 2);
        goto(1510); check_eq("mid_drop", int'(grant_id), 3);
                    check_led("mid_drop_led", 0);
        req = 4'b0000;
        goto(1520); check_eq("idle_gv", int'(grant_valid), 0);
                    check_eq("idle_gid_hold", int'(grant_id), 3);
                    check_led("idle_led", 0);

`ifdef LED_PWM_DIM_EN
        req = 4'b0001;
        set_src(0, 3'd1, 4'd0);
        dim = 4'd4;
        do_reset();
        goto(20);
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            goto(cyc + 1);
            lit += int'(LED);
        end
        check_eq("pwm_dim4", lit, 4);
        dim = 4'd0;
        lit = 0;
        for (int i = 0; i < 32; i++) begin
            goto(cyc + 1);
            lit += int'(LED);
        end
        check_eq("pwm_dim0", lit, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_status_scheduler.md
Name: led_status_scheduler

Overview:
- Shares one front-panel status LED between NUM_REQ status sources, e.g. PHY link, DHCP, run, PTT and error.
- Each source requests the LED with a pattern code.
- Fixed-priority arbitration with a minimum hold time, so the LED never thrashes between sources.
- Generates the flash and blink-code timing itself from a 10 ms tick; sits between status logic and the LED pin.

Parameters:
- CLOCK_SPEED, 25000000, clock frequency in Hz; tick period = CLOCK_SPEED/100 clocks.
- NUM_REQ, 4, number of requesters; index 0 has the highest priority.
- MIN_HOLD, 50, minimum ticks a grant is held before a higher-priority preemption is allowed.

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- req  input  NUM_REQ  per-source LED request, level
- mode  input  3*NUM_REQ  per-source pattern, slice i = mode[3i+2:3i]
- count  input  4*NUM_REQ  per-source blink count for CODE mode, slice i = count[4i+3:4i]
- LED  output  1  LED drive, high = lit
- grant_valid  output  1  a source currently owns the LED
- grant_id  output  clog2(NUM_REQ)  index of the owning source
- tick  output  1  one-clock 10 ms strobe, for reuse by status logic

Behaviour:
- Reset (async assert, sync release):
  - LED=0, grant_valid=0, grant_id=0, tick=0.
  - Prescaler, hold and phase counters all 0; FSM in IDLE.
- Prescaler:
  - Counts 0..CLOCK_SPEED/100-1 and wraps.
  - tick=1 for exactly the one clock in which it wraps.
  - All state changes below happen only in tick cycles.
- Modes:
  - 0 OFF: LED=0.
  - 1 ON: LED=1.
  - 2 SLOW: toggle every 50 ticks.
  - 3 FAST: toggle every 10 ticks.
  - 4 CODE: count pulses, each 20 ticks on then 20 off, followed by a 100-tick gap, repeating. count=0 gives the gap only, LED off.
  - 5 VARY: two toggles at 50 ticks, then two at 10 ticks, repeating.
  - 6 and 7: treated as OFF.
- FSM states: IDLE, SHOW (modes 0/1/2/3/5), CODE_ON, CODE_OFF, CODE_GAP.
- Arbitration:
  - Winner = lowest index with req high.
  - On a re-arbitration tick:
    - The winner's mode and count are latched; grant_id=winner, grant_valid=1.
    - Hold counter cleared; phase counter cleared; LED set to the pattern's first phase (on for SLOW, FAST, VARY and CODE with count>0).
    - Outputs update in the same clock as that tick (1-clock latency from tick).
- Re-arbitration occurs on a tick when any of these holds:
  - (a) grant_valid=0 and any req is high.
  - (b) The granted req has dropped. This is immediate, ignoring MIN_HOLD.
  - (c) Hold counter ≥ MIN_HOLD and the winner differs from grant_id, or the granted source's mode/count input differs from the latched values.
  - (d) In CODE mode, at the end of CODE_GAP only. A CODE sequence is never truncated except by (b).
- No req high at a re-arbitration tick → IDLE, grant_valid=0, LED=0; grant_id holds its last value.
- Hold counter saturates at MIN_HOLD.
- A request that asserts and drops between two ticks is never seen.
- count values above 15 are impossible (4 bits). Phase counter width covers 100 ticks.
- reset_n asserted mid-pattern → immediate return to the reset state; no sequence resumes after release.

Optional Feature:
- Macro LED_PWM_DIM_EN.
- When defined:
  - Adds input port dim[3:0].
  - Whenever the pattern would drive LED=1, LED is instead 1 while a free-running 4-bit PWM counter (advancing every clock) is < dim.
  - dim=15 gives 15/16 duty; dim=0 keeps LED dark.
  - LED=0 phases are unaffected.
- When undefined: no dim port; LED is driven directly by the pattern.

Test Plan:
- Run the bench with CLOCK_SPEED=1000, so tick = every 10 clocks.
- Reset: hold reset_n=0 with req=4'b1111 → LED=0, grant_valid=0, tick never pulses; after release the first tick comes 10 clocks later and grants id 0.
- SLOW: req[2]=1, mode2=2 → grant_id=2; LED toggles every 500 clocks; first phase LED=1.
- CODE: req[1]=1, mode=4, count=3 → 3 pulses of 200 clocks on / 200 off, then 1000 clocks dark; period 2200 clocks repeats.
- Preemption under hold:
  - req[3] mode1 granted; req[0] mode3 asserts 10 ticks later → no switch until tick 50 after the grant, then grant_id=0 and LED begins FAST.
  - Dropping req[0] → regrant to 3 on the next tick.
- CODE not truncated: while id 2 is in CODE, req[0] rises after MIN_HOLD → switch only at the CODE_GAP end. Drop req[2] mid-pulse → switch on the next tick.
- LED_PWM_DIM_EN, dim=4, mode ON → LED high exactly 4 of every 16 clocks; dim=0 → LED constant 0.
